// File: rtl/note_sequence_to_keys_pkg.sv
// ---------------------------------------------------------------------------
// note_seq_pkg
// Shared types for the autoplay note sequencer: note/duration codes, the
// buffered event record, the sequencer state encoding and the note-to-key
// decode used to drive the A,S,D,F,G,H,J key lines.
// ---------------------------------------------------------------------------
package note_seq_pkg;

    typedef logic [3:0] note_t;
    typedef logic [7:0] dur_t;

    typedef struct packed {
        note_t note;
        dur_t  dur;
    } note_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } seq_state_t;

    localparam note_t NOTE_REST = 4'd7;
    localparam int    NUM_KEYS  = 7;

    // Codes 0..6 light exactly one key (bit0=A .. bit6=J); 7 and above are
    // rests and leave every key released.
    function automatic logic [NUM_KEYS-1:0] note_to_keys(input note_t note);
        logic [NUM_KEYS-1:0] k;
        k = '0;
        if (note < NOTE_REST) begin
            k = 7'b0000001 << note[2:0];
        end
        return k;
    endfunction

endpackage

// File: rtl/note_sequence_to_keys_if.sv
// ---------------------------------------------------------------------------
// note_sequence_to_keys_if
// Valid/ready event stream carrying (note, duration) pairs into the
// sequencer.
//   in_valid     source -> sink  event offered
//   in_ready     sink -> source  sink can accept this cycle
//   in_note      source -> sink  0..6 = key A..J, 7..15 = rest
//   in_duration  source -> sink  length in ticks, 0 = drop event
// ---------------------------------------------------------------------------
interface note_sequence_to_keys_if;
    import note_seq_pkg::*;

    logic  in_valid;
    logic  in_ready;
    note_t in_note;
    dur_t  in_duration;

    modport master (output in_valid, output in_note, output in_duration, input in_ready);
    modport slave  (input in_valid, input in_note, input in_duration, output in_ready);

endinterface

// File: rtl/note_sequence_to_keys_fifo.sv
// ---------------------------------------------------------------------------
// note_evt_fifo
// Synchronous FIFO of note events. rdata always shows the head entry.
//   clk, reset   clock, synchronous active-high reset
//   push, wdata  write an entry (ignored when full)
//   pop          discard the head entry (ignored when empty)
//   flush        drop all entries
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module note_evt_fifo
    import note_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  note_evt_t wdata,
    output note_evt_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    note_evt_t     mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/note_sequence_to_keys.sv
// ---------------------------------------------------------------------------
// note_sequence_to_keys
// Autoplay sequencer: buffers (note, duration) events and replays them as
// timed one-hot strobes on the A,S,D,F,G,H,J key lines.
//   clk, reset  clock, synchronous active-high reset
//   in_if       slave side of the event stream (in_ready = FIFO not full)
//   stop        abort: flush queue, release keys, return to IDLE
//   keys        registered one-hot key strobes (bit0=A .. bit6=J)
//   cur_note    registered code of the note playing, 0 when not playing
//   busy        sequencer active or events queued
//   bad_note    one-cycle pulse after a code 8..15 is popped
// Build option: define NOTE_SEQ_GAP_EN to insert a GAP_TICKS release gap
// after every note.
// ---------------------------------------------------------------------------
module note_sequence_to_keys
    import note_seq_pkg::*;
#(
    parameter int TICK_DIV   = 50_000,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_TICKS  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    note_sequence_to_keys_if.slave  in_if,
    input  logic                    stop,
    output logic [NUM_KEYS-1:0]     keys,
    output note_t                   cur_note,
    output logic                    busy,
    output logic                    bad_note
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam dur_t          GAP_LAST   = dur_t'(GAP_TICKS - 1);

    seq_state_t    state;
    seq_state_t    state_d;
    logic [PW-1:0] presc;
    dur_t          tick;
    dur_t          dur_q;
    dur_t          tick_last;
    logic          presc_last;
    logic          period_end;
    logic          release_now;
    logic          pop;
    logic          load;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    note_evt_t     wr_evt;
    note_evt_t     head;

    assign in_if.in_ready = !fifo_full;
    assign fifo_push      = in_if.in_valid && !fifo_full && !stop;
    assign wr_evt         = '{note: in_if.in_note, dur: in_if.in_duration};
    assign busy           = (state != IDLE) || !fifo_empty;

    note_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .flush (stop),
        .wdata (wr_evt),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // GAP can only be reached when the gap option is built in; otherwise the
    // period always ends on the loaded duration.
    assign tick_last   = (state == GAP) ? GAP_LAST : dur_q - 8'd1;
    assign presc_last  = (presc == PRESC_LAST);
    assign period_end  = presc_last && (tick == tick_last);
    assign release_now = (state != IDLE) && period_end && !load;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and pop/load decisions. At the end of a timed period the
    // next event is popped and loaded in the same cycle so consecutive notes
    // join without a release cycle; zero-duration heads are popped and lost.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        load    = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head.dur != '0) begin
                            load    = 1'b1;
                            state_d = PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (period_end) begin
`ifdef NOTE_SEQ_GAP_EN
                        state_d = GAP;
`else
                        state_d = IDLE;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                            if (head.dur != '0) begin
                                load    = 1'b1;
                                state_d = PLAY;
                            end
                        end
`endif
                    end
                end
`ifdef NOTE_SEQ_GAP_EN
                GAP: begin
                    if (period_end) begin
                        state_d = IDLE;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                            if (head.dur != '0) begin
                                load    = 1'b1;
                                state_d = PLAY;
                            end
                        end
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Timing counters and registered outputs. Counters restart on every load
    // and on every release so the following period (note or gap) starts at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            tick     <= '0;
            dur_q    <= '0;
            keys     <= '0;
            cur_note <= '0;
            bad_note <= 1'b0;
        end else begin
            bad_note <= pop && head.note[3];
            if (stop) begin
                presc    <= '0;
                tick     <= '0;
                keys     <= '0;
                cur_note <= '0;
            end else if (load) begin
                presc    <= '0;
                tick     <= '0;
                dur_q    <= head.dur;
                keys     <= note_to_keys(head.note);
                cur_note <= head.note;
            end else if (release_now) begin
                presc    <= '0;
                tick     <= '0;
                keys     <= '0;
                cur_note <= '0;
            end else if (state != IDLE) begin
                if (presc_last) begin
                    presc <= '0;
                    tick  <= tick + 8'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_note_sequence_to_keys.sv
// ---------------------------------------------------------------------------
// tb_note_sequence_to_keys
// Directed self-checking bench for note_sequence_to_keys with TICK_DIV=4,
// FIFO_DEPTH=4, GAP_TICKS=1. Expected cycle positions shift by one gap
// (4 cycles) when NOTE_SEQ_GAP_EN is defined.
// ---------------------------------------------------------------------------
module tb_note_sequence_to_keys;
    import note_seq_pkg::*;

    localparam int TICK_DIV = 4;
`ifdef NOTE_SEQ_GAP_EN
    localparam int GAPC = 4;
`else
    localparam int GAPC = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       stop;
    logic [6:0] keys;
    note_t      cur_note;
    logic       busy;
    logic       bad_note;
    int         n_checks = 0;
    int         n_errors = 0;
    int         waited;

    note_sequence_to_keys_if bus ();

    note_sequence_to_keys #(
        .TICK_DIV   (TICK_DIV),
        .FIFO_DEPTH (4),
        .GAP_TICKS  (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_if    (bus),
        .stop     (stop),
        .keys     (keys),
        .cur_note (cur_note),
        .busy     (busy),
        .bad_note (bad_note)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic applyStimulus(input logic valid, input note_t note,
                                 input dur_t dur, input logic stp);
        bus.in_valid    = valid;
        bus.in_note     = note;
        bus.in_duration = dur;
        stop            = stp;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hard stop in case the sequence stalls somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
        reset = 1'b1;
        stepn(3);
        reset = 1'b0;
        checkOutput("rst_keys", 32'(keys), 32'd0);
        checkOutput("rst_cur_note", 32'(cur_note), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_bad_note", 32'(bad_note), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single note (2,3): 12 held cycles starting 2 cycles after the push
        $display("[TB] single note");
        applyStimulus(1'b1, 4'd2, 8'd3, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
        checkOutput("t1_pop_cycle_keys", 32'(keys), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            checkOutput("t1_keys_held", 32'(keys), 32'h04);
        end
        checkOutput("t1_cur_note", 32'(cur_note), 32'd2);
        step();
        checkOutput("t1_keys_released", 32'(keys), 32'd0);
        checkOutput("t1_cur_note_cleared", 32'(cur_note), 32'd0);
        stepn(GAPC);
        checkOutput("t1_busy_done", 32'(busy), 32'd0);

        // Back-to-back (0,1),(6,2)
        $display("[TB] back-to-back notes");
        applyStimulus(1'b1, 4'd0, 8'd1, 1'b0);
        step();
        applyStimulus(1'b1, 4'd6, 8'd2, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_key_a", 32'(keys), 32'h01);
            step();
        end
        for (int i = 0; i < GAPC; i++) begin
            checkOutput("t2_gap_zero", 32'(keys), 32'd0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_key_j", 32'(keys), 32'h40);
            step();
        end
        checkOutput("t2_keys_released", 32'(keys), 32'd0);
        stepn(GAPC);
        checkOutput("t2_busy_done", 32'(busy), 32'd0);

        // FIFO full back-pressure while a long note plays
        $display("[TB] fifo full");
        applyStimulus(1'b1, 4'd1, 8'd255, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
        step();
        checkOutput("t3_first_playing", 32'(keys), 32'h02);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, note_t'(2 + i), 8'd255, 1'b0);
            checkOutput("t3_ready_before_push", 32'(bus.in_ready), 32'd1);
            step();
        end
        applyStimulus(1'b1, 4'd6, 8'd255, 1'b0);
        checkOutput("t3_full_not_ready", 32'(bus.in_ready), 32'd0);
        waited = 0;
        while (!bus.in_ready && waited < 2000) begin
            step();
            waited++;
        end
        checkOutput("t3_ready_wait_cycles", 32'(waited), 32'(1016 + GAPC));
        checkOutput("t3_second_playing", 32'(keys), 32'h04);
        step();
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
        checkOutput("t3_full_again", 32'(bus.in_ready), 32'd0);

        // Stop mid-play with events queued; push in the same cycle is ignored
        $display("[TB] stop");
        applyStimulus(1'b1, 4'd0, 8'd5, 1'b1);
        step();
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
        checkOutput("t5_keys", 32'(keys), 32'd0);
        checkOutput("t5_cur_note", 32'(cur_note), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        checkOutput("t5_still_idle", 32'(busy), 32'd0);
        checkOutput("t5_still_silent", 32'(keys), 32'd0);

        // (3,0) dropped, (7,2) rest, (9,1) bad rest
        $display("[TB] rests and bad note");
        applyStimulus(1'b1, 4'd3, 8'd0, 1'b0);
        step();
        applyStimulus(1'b1, 4'd7, 8'd2, 1'b0);
        step();
        applyStimulus(1'b1, 4'd9, 8'd1, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
        checkOutput("t4_cur_note_rest", 32'(cur_note), 32'd7);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t4_rest_keys", 32'(keys), 32'd0);
            checkOutput("t4_rest_busy", 32'(busy), 32'd1);
            checkOutput("t4_rest_no_bad", 32'(bad_note), 32'd0);
            step();
        end
        for (int i = 0; i < GAPC; i++) begin
            checkOutput("t4_gap_no_bad", 32'(bad_note), 32'd0);
            step();
        end
        checkOutput("t4_bad_pulse", 32'(bad_note), 32'd1);
        checkOutput("t4_cur_note_bad", 32'(cur_note), 32'd9);
        checkOutput("t4_bad_keys", 32'(keys), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t4_bad_single", 32'(bad_note), 32'd0);
            checkOutput("t4_bad_keys_zero", 32'(keys), 32'd0);
            checkOutput("t4_bad_busy", 32'(busy), 32'd1);
        end
        step();
        checkOutput("t4_cur_note_cleared", 32'(cur_note), 32'd0);
        stepn(GAPC);
        checkOutput("t4_busy_done", 32'(busy), 32'd0);

        // Reset mid-play loses the queue
        $display("[TB] reset mid-play");
        applyStimulus(1'b1, 4'd4, 8'd5, 1'b0);
        step();
        applyStimulus(1'b1, 4'd5, 8'd1, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
        checkOutput("t6_playing", 32'(keys), 32'h10);
        stepn(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("t6_keys", 32'(keys), 32'd0);
        checkOutput("t6_cur_note", 32'(cur_note), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_bad_note", 32'(bad_note), 32'd0);
        checkOutput("t6_in_ready", 32'(bus.in_ready), 32'd1);
        stepn(3);
        checkOutput("t6_queue_lost_keys", 32'(keys), 32'd0);
        checkOutput("t6_queue_lost_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
